// File: rtl/key_entry_if.sv
// Keypad-side bundle for the key entry register: command inputs from the
// keypad decoder and the buffer/commit outputs toward the alarm logic.
interface key_entry_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [DIGIT_W-1:0] key;
  logic               shift;
  logic               backspace;
  logic               clear;
  logic               commit;
  logic [BUF_W-1:0]   key_buffer;
  logic [CNT_W-1:0]   digit_count;
  logic               full;
  logic               key_reject;
  logic               load_pulse;
  logic [BUF_W-1:0]   load_value;
  logic               timeout_flag;

  modport master (
    output key, shift, backspace, clear, commit,
    input  key_buffer, digit_count, full, key_reject,
    input  load_pulse, load_value, timeout_flag
  );

  modport slave (
    input  key, shift, backspace, clear, commit,
    output key_buffer, digit_count, full, key_reject,
    output load_pulse, load_value, timeout_flag
  );
endinterface

// File: rtl/key_entry_register.sv
// N-digit decimal key entry buffer with backspace, clear, idle timeout and
// a commit handshake that hands a full entry to the alarm/time-set logic.
module key_entry_register #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_DIGIT      = 9,
  parameter int OVERWRITE      = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  key_entry_if.slave  bus
);
  localparam int BUF_W  = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam bit OVR_EN     = (OVERWRITE != 0);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_DIGITS);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = TIMEOUT_EN ? IDLE_W'(TIMEOUT_CYCLES - 1) : IDLE_W'(0);

  logic [BUF_W-1:0]  buf_r,  buf_s;
  logic [CNT_W-1:0]  cnt_r,  cnt_s;
  logic [BUF_W-1:0]  load_r, load_s;
  logic [IDLE_W-1:0] idle_r, idle_s;
  logic              reject_r, reject_s;
  logic              lpulse_r, lpulse_s;
  logic              tflag_r,  tflag_s;

  logic              full_s;
  logic              any_cmd_s;
  logic              timeout_hit_s;
  logic              key_ok_s;
  logic              activity_s;
  logic [31:0]       key_ext_s;

  assign full_s        = (cnt_r == CNT_FULL);
  assign any_cmd_s     = bus.clear | bus.backspace | bus.shift | bus.commit;
  assign timeout_hit_s = TIMEOUT_EN && (cnt_r != {CNT_W{1'b0}}) &&
                         (idle_r == IDLE_LAST) && !any_cmd_s;
  // Widen before comparing so a MAX_DIGIT beyond the key range never truncates.
  assign key_ext_s     = 32'(bus.key);
  assign key_ok_s      = (key_ext_s <= 32'(MAX_DIGIT));

  // Next-state selection: one command acts per cycle in priority order.
  always_comb begin
    buf_s      = buf_r;
    cnt_s      = cnt_r;
    load_s     = load_r;
    reject_s   = 1'b0;
    lpulse_s   = 1'b0;
    tflag_s    = 1'b0;
    activity_s = 1'b0;
    if (bus.clear) begin
      buf_s      = {BUF_W{1'b0}};
      cnt_s      = {CNT_W{1'b0}};
      activity_s = 1'b1;
    end else if (timeout_hit_s) begin
      buf_s   = {BUF_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
      tflag_s = 1'b1;
    end else if (bus.backspace) begin
      if (cnt_r != {CNT_W{1'b0}}) begin
        buf_s      = {{DIGIT_W{1'b0}}, buf_r[BUF_W-1:DIGIT_W]};
        cnt_s      = cnt_r - CNT_W'(1);
        activity_s = 1'b1;
      end else begin
        buf_s = buf_r;
      end
    end else if (bus.shift) begin
      activity_s = 1'b1;
      if (key_ok_s && (!full_s || OVR_EN)) begin
        buf_s = {buf_r[BUF_W-DIGIT_W-1:0], bus.key};
        if (full_s) begin
          cnt_s = cnt_r;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        reject_s = 1'b1;
      end
    end else if (bus.commit) begin
      if (full_s) begin
        load_s     = buf_r;
        lpulse_s   = 1'b1;
        buf_s      = {BUF_W{1'b0}};
        cnt_s      = {CNT_W{1'b0}};
        activity_s = 1'b1;
      end else begin
        load_s = load_r;
      end
    end else begin
      buf_s = buf_r;
    end
  end

  // Idle counter: restarts on activity, otherwise saturates at TIMEOUT_CYCLES.
  always_comb begin
    idle_s = idle_r;
    if (activity_s) begin
      idle_s = {IDLE_W{1'b0}};
    end else if (idle_r != IDLE_SAT) begin
      idle_s = idle_r + IDLE_W'(1);
    end else begin
      idle_s = idle_r;
    end
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_r    <= {BUF_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      load_r   <= {BUF_W{1'b0}};
      idle_r   <= {IDLE_W{1'b0}};
      reject_r <= 1'b0;
      lpulse_r <= 1'b0;
      tflag_r  <= 1'b0;
    end else begin
      buf_r    <= buf_s;
      cnt_r    <= cnt_s;
      load_r   <= load_s;
      idle_r   <= idle_s;
      reject_r <= reject_s;
      lpulse_r <= lpulse_s;
      tflag_r  <= tflag_s;
    end
  end

  assign bus.key_buffer   = buf_r;
  assign bus.digit_count  = cnt_r;
  assign bus.full         = full_s;
  assign bus.key_reject   = reject_r;
  assign bus.load_pulse   = lpulse_r;
  assign bus.load_value   = load_r;
  assign bus.timeout_flag = tflag_r;
endmodule

// File: tb/tb_key_entry_register.sv
// Directed bench: a refuse-when-full instance and an overwrite instance driven
// with identical stimulus, checked against hand-computed values.
module tb_key_entry_register;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  key_entry_if #(.NUM_DIGITS(4), .DIGIT_W(4)) if0 ();
  key_entry_if #(.NUM_DIGITS(4), .DIGIT_W(4)) if1 ();

  key_entry_register #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9),
                       .OVERWRITE(0), .TIMEOUT_CYCLES(16))
    dut0 (.clk(clk), .reset(reset), .bus(if0));

  key_entry_register #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9),
                       .OVERWRITE(1), .TIMEOUT_CYCLES(16))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] k, input logic sh, input logic bs,
                       input logic cl, input logic cm);
    if0.key = k; if0.shift = sh; if0.backspace = bs; if0.clear = cl; if0.commit = cm;
    if1.key = k; if1.shift = sh; if1.backspace = bs; if1.clear = cl; if1.commit = cm;
  endtask

  // One edge with the given command, then inputs return to idle.
  task automatic step(input logic [3:0] k, input logic sh, input logic bs,
                      input logic cl, input logic cm);
    drive(k, sh, bs, cl, cm);
    @(posedge clk);
    #1;
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [3:0] k);
    step(k, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({if0.key_buffer, 13'(if0.digit_count), if0.full, if0.key_reject, if0.load_pulse,
         if0.timeout_flag, if0.load_value} !== 64'h0)
      $display("FAIL reset_state: buf=%h cnt=%0d full=%b rej=%b lp=%b to=%b lv=%h required all 0",
               if0.key_buffer, if0.digit_count, if0.full, if0.key_reject,
               if0.load_pulse, if0.timeout_flag, if0.load_value);
    else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_shift;
    enter(4'h1);
    total_cnt++;
    if (if0.key_buffer !== 16'h0001 || if0.digit_count !== 3'd1)
      $display("FAIL shift_first: buf=%h cnt=%0d required 0001/1", if0.key_buffer, if0.digit_count);
    else pass_cnt++;
    enter(4'h2);
    enter(4'h5);
    enter(4'h9);
    total_cnt++;
    if (if0.key_buffer !== 16'h1259 || if0.digit_count !== 3'd4 || if0.full !== 1'b1 ||
        if0.key_reject !== 1'b0)
      $display("FAIL shift_four: buf=%h cnt=%0d full=%b rej=%b required 1259/4/1/0",
               if0.key_buffer, if0.digit_count, if0.full, if0.key_reject);
    else pass_cnt++;
  endtask

  task automatic test_full;
    enter(4'h3);
    total_cnt++;
    if (if0.key_reject !== 1'b1 || if0.key_buffer !== 16'h1259 || if0.digit_count !== 3'd4)
      $display("FAIL full_refuse: rej=%b buf=%h cnt=%0d required 1/1259/4",
               if0.key_reject, if0.key_buffer, if0.digit_count);
    else pass_cnt++;
    total_cnt++;
    if (if1.key_reject !== 1'b0 || if1.key_buffer !== 16'h2593 || if1.digit_count !== 3'd4)
      $display("FAIL full_overwrite: rej=%b buf=%h cnt=%0d required 0/2593/4",
               if1.key_reject, if1.key_buffer, if1.digit_count);
    else pass_cnt++;
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (if0.key_reject !== 1'b0)
      $display("FAIL reject_one_cycle: rej=%b required 0", if0.key_reject);
    else pass_cnt++;
  endtask

  task automatic test_backspace;
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    enter(4'h1);
    enter(4'h2);
    enter(4'h3);
    step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (if0.key_buffer !== 16'h0012 || if0.digit_count !== 3'd2)
      $display("FAIL backspace: buf=%h cnt=%0d required 0012/2", if0.key_buffer, if0.digit_count);
    else pass_cnt++;
    step(4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (if0.key_buffer !== 16'h0001 || if0.digit_count !== 3'd1 || if0.key_reject !== 1'b0)
      $display("FAIL backspace_over_shift: buf=%h cnt=%0d rej=%b required 0001/1/0",
               if0.key_buffer, if0.digit_count, if0.key_reject);
    else pass_cnt++;
    step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (if0.key_buffer !== 16'h0000 || if0.digit_count !== 3'd0)
      $display("FAIL backspace_empty: buf=%h cnt=%0d required 0000/0", if0.key_buffer, if0.digit_count);
    else pass_cnt++;
  endtask

  task automatic test_bad_key;
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    enter(4'hA);
    total_cnt++;
    if (if0.key_reject !== 1'b1 || if0.digit_count !== 3'd0 || if0.key_buffer !== 16'h0000)
      $display("FAIL bad_key: rej=%b cnt=%0d buf=%h required 1/0/0000",
               if0.key_reject, if0.digit_count, if0.key_buffer);
    else pass_cnt++;
    enter(4'h0);
    total_cnt++;
    if (if0.key_buffer !== 16'h0000 || if0.digit_count !== 3'd1 || if0.key_reject !== 1'b0)
      $display("FAIL leading_zero: buf=%h cnt=%0d rej=%b required 0000/1/0",
               if0.key_buffer, if0.digit_count, if0.key_reject);
    else pass_cnt++;
  endtask

  task automatic test_commit;
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    enter(4'h2);
    enter(4'h3);
    enter(4'h4);
    enter(4'h5);
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (if0.load_pulse !== 1'b1 || if0.load_value !== 16'h2345 ||
        if0.key_buffer !== 16'h0000 || if0.digit_count !== 3'd0)
      $display("FAIL commit_full: lp=%b lv=%h buf=%h cnt=%0d required 1/2345/0000/0",
               if0.load_pulse, if0.load_value, if0.key_buffer, if0.digit_count);
    else pass_cnt++;
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (if0.load_pulse !== 1'b0 || if0.load_value !== 16'h2345)
      $display("FAIL commit_hold: lp=%b lv=%h required 0/2345", if0.load_pulse, if0.load_value);
    else pass_cnt++;
    enter(4'h6);
    enter(4'h7);
    enter(4'h8);
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (if0.load_pulse !== 1'b0 || if0.load_value !== 16'h2345 ||
        if0.key_buffer !== 16'h0678 || if0.digit_count !== 3'd3)
      $display("FAIL commit_not_full: lp=%b lv=%h buf=%h cnt=%0d required 0/2345/0678/3",
               if0.load_pulse, if0.load_value, if0.key_buffer, if0.digit_count);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int early;
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    enter(4'h7);
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (if0.timeout_flag !== 1'b0 || if0.digit_count !== 3'd1) early++;
    end
    total_cnt++;
    if (early != 0)
      $display("FAIL timeout_early: bad idle edges=%0d required 0", early);
    else pass_cnt++;
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (if0.timeout_flag !== 1'b1 || if0.key_buffer !== 16'h0000 || if0.digit_count !== 3'd0)
      $display("FAIL timeout_fire: to=%b buf=%h cnt=%0d required 1/0000/0",
               if0.timeout_flag, if0.key_buffer, if0.digit_count);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) step(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (if0.timeout_flag !== 1'b0)
      $display("FAIL timeout_empty: to=%b required 0", if0.timeout_flag);
    else pass_cnt++;
    enter(4'h8);
    step(4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (if0.key_buffer !== 16'h0000 || if0.digit_count !== 3'd0 || if0.key_reject !== 1'b0)
      $display("FAIL clear_over_shift: buf=%h cnt=%0d rej=%b required 0000/0/0",
               if0.key_buffer, if0.digit_count, if0.key_reject);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_entry;
    enter(4'h1);
    enter(4'h2);
    enter(4'h3);
    enter(4'h4);
    reset = 1'b0;
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    total_cnt++;
    if (if0.load_pulse !== 1'b0 || if0.load_value !== 16'h0000 ||
        if0.key_buffer !== 16'h0000 || if0.digit_count !== 3'd0)
      $display("FAIL reset_commit: lp=%b lv=%h buf=%h cnt=%0d required 0/0000/0000/0",
               if0.load_pulse, if0.load_value, if0.key_buffer, if0.digit_count);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset;
    test_shift;
    test_full;
    test_backspace;
    test_bad_key;
    test_commit;
    test_timeout;
    test_reset_mid_entry;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
